// File: rtl/prio_intr_enc_pkg.sv
// Shared constants and the highest-set-bit helper for the prioritised interrupt encoder.
// Compile with PRIO_ENC_MASK_EN defined to enable the per-line mask register.
package prio_enc_pkg;

    localparam int MAX_N = 64;
    localparam int MAX_W = $clog2(MAX_N);

    // Idle encoding of a_n; users take the low W bits by cast.
    localparam logic [MAX_W-1:0] ALL_ONES_A = '1;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } msb_t;

    // Scans upward so the last set bit seen is the highest one.
    function automatic msb_t msb_idx(input logic [MAX_N-1:0] vec);
        msb_t res;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = 32'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_intr_enc_if.sv
// Request/acknowledge and encoded-output bundle of prio_intr_enc.
// mask_ld/mask_d exist only when PRIO_ENC_MASK_EN is defined.
interface prio_intr_enc_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         ei_n;
    logic [N-1:0] req_n;
    logic         ack;
    logic         eoi;
`ifdef PRIO_ENC_MASK_EN
    logic         mask_ld;
    logic [N-1:0] mask_d;
`endif

    logic [W-1:0] a_n;
    logic         gs_n;
    logic         eo_n;
    logic         irq;
    logic         isv;
    logic [W-1:0] lvl;

`ifdef PRIO_ENC_MASK_EN
    modport master (
        output ei_n, req_n, ack, eoi, mask_ld, mask_d,
        input  a_n, gs_n, eo_n, irq, isv, lvl
    );

    modport slave (
        input  ei_n, req_n, ack, eoi, mask_ld, mask_d,
        output a_n, gs_n, eo_n, irq, isv, lvl
    );
`else
    modport master (
        output ei_n, req_n, ack, eoi,
        input  a_n, gs_n, eo_n, irq, isv, lvl
    );

    modport slave (
        input  ei_n, req_n, ack, eoi,
        output a_n, gs_n, eo_n, irq, isv, lvl
    );
`endif

endinterface

// File: rtl/prio_intr_enc_msb.sv
// Combinational highest-set-bit finder; idx is 0 when no bit is set.
module prio_msb
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    msb_t res;

    always_comb begin
        res   = msb_idx(MAX_N'(vec));
        idx   = W'(res.idx);
        found = res.found;
    end

endmodule

// File: rtl/prio_intr_enc.sv
// Sticky priority interrupt encoder with in-service nesting and 74148-style cascade pins.
// Optional mask register is enabled by defining PRIO_ENC_MASK_EN.
module prio_intr_enc
    import prio_enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    prio_intr_enc_if.slave bus
);

    localparam int W = $clog2(N);

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] isr_q;
    logic [N-1:0] isr_d;
    logic [N-1:0] mask;
    logic [N-1:0] elig;

    logic [W-1:0] p_idx;
    logic [W-1:0] l_idx;
    logic         e_any;
    logic         isr_any;
    logic         en;
    logic         irq;
    logic         do_ack;
    logic         do_eoi;

`ifdef PRIO_ENC_MASK_EN
    logic [N-1:0] msk_q;
    logic [N-1:0] msk_d;

    always_comb begin
        msk_d = msk_q;
        if (bus.mask_ld) begin
            msk_d = bus.mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msk_q <= '0;
        end else begin
            msk_q <= msk_d;
        end
    end

    assign mask = msk_q;
`else
    assign mask = '0;
`endif

    assign elig = pend_q & ~mask;
    assign en   = ~bus.ei_n;

    prio_msb #(.N(N)) u_elig_msb (
        .vec   (elig),
        .idx   (p_idx),
        .found (e_any)
    );

    prio_msb #(.N(N)) u_isr_msb (
        .vec   (isr_q),
        .idx   (l_idx),
        .found (isr_any)
    );

    // Only a strictly higher level than the one in service may interrupt.
    assign irq    = en & e_any & (~isr_any | (p_idx > l_idx));
    assign do_ack = bus.ack & irq;
    assign do_eoi = bus.eoi & isr_any;

    // Clears are applied before sets so a still-held request re-latches on ack,
    // and an ack landing on the level being retired keeps that bit set.
    always_comb begin
        pend_d = pend_q;
        isr_d  = isr_q;
        if (do_ack) begin
            pend_d[p_idx] = 1'b0;
        end
        if (en) begin
            pend_d = pend_d | ~bus.req_n;
        end
        if (do_eoi) begin
            isr_d[l_idx] = 1'b0;
        end
        if (do_ack) begin
            isr_d[p_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            isr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            isr_q  <= isr_d;
        end
    end

    assign bus.a_n  = (en & e_any) ? ~p_idx : W'(ALL_ONES_A);
    assign bus.gs_n = ~(en & e_any);
    assign bus.eo_n = ~(en & ~e_any);
    assign bus.irq  = irq;
    assign bus.isv  = isr_any;
    assign bus.lvl  = isr_any ? l_idx : '0;

endmodule

// File: tb/tb_prio_intr_enc.sv
// Self-checking bench for prio_intr_enc (N=8): set-based reference model plus directed literal checks.
// Define PRIO_ENC_MASK_EN to also exercise the mask register.
module tb_prio_intr_enc;

   logic clk;
   logic rst;

   int checks;
   int errors;

   prio_intr_enc_if #(.N(8)) bus ();

   prio_intr_enc #(.N(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference state: the pending, in-service and mask sets as plain bit arrays
   logic [7:0] m_pend;
   logic [7:0] m_isr;
   logic [7:0] m_mask;
   bit         m_valid;

`ifdef PRIO_ENC_MASK_EN
   logic       tb_mask_ld;
   logic [7:0] tb_mask_d;
`endif

   function automatic int highest(input logic [7:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference sets from the rules, using pre-edge inputs
   always @(posedge clk) begin : model_update
      int p;
      int l;
      bit en;
      bit grant;
      if (rst) begin
         m_pend  = '0;
         m_isr   = '0;
         m_mask  = '0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         en    = (bus.ei_n == 1'b0);
         p     = highest(m_pend & ~m_mask);
         l     = highest(m_isr);
         grant = en && (p >= 0) && ((l < 0) || (p > l));
         if (bus.ack && grant) m_pend[p] = 1'b0;
         if (en) m_pend = m_pend | ~bus.req_n;
         if (bus.eoi && (l >= 0)) m_isr[l] = 1'b0;
         if (bus.ack && grant) m_isr[p] = 1'b1;
`ifdef PRIO_ENC_MASK_EN
         if (tb_mask_ld) m_mask = tb_mask_d;
`endif
      end
   end

   // Every cycle, compare all outputs against what the sets imply
   always @(posedge clk) begin : compare_proc
      int p;
      int l;
      bit en;
      bit any;
      #3;
      if (m_valid) begin
         en  = (bus.ei_n == 1'b0);
         p   = highest(m_pend & ~m_mask);
         l   = highest(m_isr);
         any = en && (p >= 0);
         cmp("cyc.a_n",  int'(bus.a_n),  any ? (7 - p) : 7);
         cmp("cyc.gs_n", int'(bus.gs_n), any ? 0 : 1);
         cmp("cyc.eo_n", int'(bus.eo_n), (en && (p < 0)) ? 0 : 1);
         cmp("cyc.irq",  int'(bus.irq),  (any && ((l < 0) || (p > l))) ? 1 : 0);
         cmp("cyc.isv",  int'(bus.isv),  (l >= 0) ? 1 : 0);
         cmp("cyc.lvl",  int'(bus.lvl),  (l >= 0) ? l : 0);
      end
   end

   task automatic applyStimulus(input logic r, input logic ei, input logic [7:0] req,
                                input logic a, input logic e);
      @(negedge clk);
      rst       = r;
      bus.ei_n  = ei;
      bus.req_n = req;
      bus.ack   = a;
      bus.eoi   = e;
`ifdef PRIO_ENC_MASK_EN
      bus.mask_ld = tb_mask_ld;
      bus.mask_d  = tb_mask_d;
`endif
      @(posedge clk);
      #3;
   endtask

   task automatic checkOutput(input string tag, input int a_n, input int gs_n, input int eo_n,
                              input int irq, input int isv, input int lvl);
      cmp({tag, ".a_n"},  int'(bus.a_n),  a_n);
      cmp({tag, ".gs_n"}, int'(bus.gs_n), gs_n);
      cmp({tag, ".eo_n"}, int'(bus.eo_n), eo_n);
      cmp({tag, ".irq"},  int'(bus.irq),  irq);
      cmp({tag, ".isv"},  int'(bus.isv),  isv);
      cmp({tag, ".lvl"},  int'(bus.lvl),  lvl);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      m_valid = 1'b0;
      m_pend  = '0;
      m_isr   = '0;
      m_mask  = '0;
      rst       = 1'b1;
      bus.ei_n  = 1'b0;
      bus.req_n = 8'hFF;
      bus.ack   = 1'b0;
      bus.eoi   = 1'b0;
`ifdef PRIO_ENC_MASK_EN
      tb_mask_ld  = 1'b0;
      tb_mask_d   = 8'h00;
      bus.mask_ld = 1'b0;
      bus.mask_d  = 8'h00;
`endif

      // Reset state
      applyStimulus(1, 0, 8'hFF, 0, 0);
      applyStimulus(1, 0, 8'hFF, 0, 0);
      applyStimulus(0, 0, 8'hFF, 0, 0);
      checkOutput("reset", 3'b111, 1, 0, 0, 0, 0);

      // One-cycle pulse on line 5, then sticky after release
      applyStimulus(0, 0, 8'hDF, 0, 0);
      checkOutput("req5", 3'b010, 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 8'hFF, 0, 0);
      checkOutput("req5_sticky", 3'b010, 0, 1, 1, 0, 0);

      // Add line 2, ack grants 5; 2 stays pending but cannot interrupt
      applyStimulus(0, 0, 8'hFB, 0, 0);
      applyStimulus(0, 0, 8'hFF, 1, 0);
      checkOutput("ack5", 3'b101, 0, 1, 0, 1, 5);

      // Line 7 outranks the level in service
      applyStimulus(0, 0, 8'h7F, 0, 0);
      checkOutput("req7_nest", 3'b000, 0, 1, 1, 1, 5);

      // ack and eoi together: retire 5, enter 7
      applyStimulus(0, 0, 8'hFF, 1, 1);
      checkOutput("ack_eoi", 3'b101, 0, 1, 0, 1, 7);

      // Retire 7: line 2 may interrupt again
      applyStimulus(0, 0, 8'hFF, 0, 1);
      checkOutput("eoi7", 3'b101, 0, 1, 1, 0, 0);

      // Disabled: outputs idle, line 4 must not latch
      applyStimulus(0, 1, 8'hEF, 0, 0);
      checkOutput("ei_off", 3'b111, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 8'hFF, 0, 0);
      checkOutput("ei_on", 3'b101, 0, 1, 1, 0, 0);

      // Grant 2; nothing else pending
      applyStimulus(0, 0, 8'hFF, 1, 0);
      checkOutput("ack2", 3'b111, 1, 0, 0, 1, 2);
      applyStimulus(0, 0, 8'hFF, 0, 1);
      applyStimulus(0, 0, 8'hFF, 1, 0);
      checkOutput("ack_ignored", 3'b111, 1, 0, 0, 0, 0);

      // Held request re-latches on its own ack
      applyStimulus(0, 0, 8'hBF, 0, 0);
      applyStimulus(0, 0, 8'hBF, 1, 0);
      checkOutput("relatch6", 3'b001, 0, 1, 0, 1, 6);
      applyStimulus(0, 0, 8'hFF, 0, 1);
      checkOutput("eoi6", 3'b001, 0, 1, 1, 0, 0);

      // Reset mid-service wins over ack/eoi
      applyStimulus(0, 0, 8'hFD, 1, 0);
      applyStimulus(1, 0, 8'hFF, 1, 1);
      checkOutput("rst_mid", 3'b111, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 8'hFF, 0, 0);

`ifdef PRIO_ENC_MASK_EN
      // Masked line 7 latches but is skipped; unmasking restores it
      applyStimulus(0, 0, 8'h77, 0, 0);
      tb_mask_ld = 1'b1;
      tb_mask_d  = 8'h80;
      applyStimulus(0, 0, 8'hFF, 0, 0);
      checkOutput("mask7", 3'b100, 0, 1, 1, 0, 0);
      tb_mask_d  = 8'h00;
      applyStimulus(0, 0, 8'hFF, 0, 0);
      tb_mask_ld = 1'b0;
      checkOutput("unmask7", 3'b000, 0, 1, 1, 0, 0);
`endif

      // Mixed traffic checked by the per-cycle model
      for (int i = 0; i < 300; i++) begin
`ifdef PRIO_ENC_MASK_EN
         tb_mask_ld = ($urandom_range(0, 9) == 0);
         tb_mask_d  = 8'($urandom) & 8'($urandom);
`endif
         applyStimulus((i % 97) == 50,
                       $urandom_range(0, 7) == 0,
                       ~(8'($urandom) & 8'($urandom) & 8'($urandom)),
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0);
      end
`ifdef PRIO_ENC_MASK_EN
      tb_mask_ld = 1'b0;
`endif
      applyStimulus(0, 0, 8'hFF, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
